overlay_fetch_ctrl: RTL

Per-line prefetch controller for the HDMI overlay path. During each horizontal blanking interval it fetches the next overlay image row from DDR over a burst read port. It writes that row into one bank of a ping-pong line buffer and hands the completed bank to the pixel mux at the next line start. It sits between the video timing counters (hCount/vCount, DE) and the DDR read master.

---
 rtl/overlay_pkg.sv | 20 ++
 rtl/ovl_burst_reader.sv | 107 ++++++++++
 rtl/overlay_fetch_ctrl.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/overlay_pkg.sv
// rtl/overlay_pkg.sv - shared state type and constants for the overlay row prefetch
package overlay_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_DATA,
    ST_DONE
  } fetch_state_e;

  localparam int unsigned OVL_BURST_LEN = 16;
  localparam int unsigned OVL_WIDTH     = 256;
  localparam int unsigned LB_ADDR_W     = $clog2(OVL_WIDTH);

  // Line-buffer address width for a given row width; never narrower than one bit.
  function automatic int unsigned lb_addr_w(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/ovl_burst_reader.sv
// rtl/ovl_burst_reader.sv - issues the bursts of one overlay row and writes its beats into the line buffer
module ovl_burst_reader
  import overlay_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 24,
  parameter int unsigned OVL_W     = OVL_WIDTH,
  parameter int unsigned BURST_LEN = OVL_BURST_LEN
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          go_i,
  input  logic [ADDR_W-1:0]             row_addr_i,
  input  logic                          bank_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          rd_req_o,
  output logic [ADDR_W-1:0]             rd_addr_o,
  output logic [7:0]                    rd_len_o,
  input  logic                          rd_ready_i,
  input  logic                          rd_valid_i,
  input  logic [DATA_W-1:0]             rd_data_i,
  output logic                          lb_we_o,
  output logic                          lb_bank_o,
  output logic [lb_addr_w(OVL_W)-1:0]   lb_addr_o,
  output logic [DATA_W-1:0]             lb_wdata_o
);

  localparam int unsigned LB_AW = lb_addr_w(OVL_W);

  fetch_state_e       state_q;
  logic               rd_req_q;
  logic [ADDR_W-1:0]  rd_addr_q;
  logic [LB_AW-1:0]   pix_q;
  logic [7:0]         beat_q;
  logic               lb_we_q;
  logic               lb_bank_q;
  logic [LB_AW-1:0]   lb_addr_q;
  logic [DATA_W-1:0]  lb_wdata_q;

  // Row fetch FSM: request a burst, collect its beats, repeat until the row is complete.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      rd_req_q   <= 1'b0;
      rd_addr_q  <= '0;
      pix_q      <= '0;
      beat_q     <= '0;
      lb_we_q    <= 1'b0;
      lb_bank_q  <= 1'b0;
      lb_addr_q  <= '0;
      lb_wdata_q <= '0;
    end else begin
      lb_we_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          state_q <= ST_IDLE;
          if (go_i) begin
            state_q   <= ST_REQ;
            rd_req_q  <= 1'b1;
            rd_addr_q <= row_addr_i;
            pix_q     <= '0;
            beat_q    <= '0;
          end
        end
        ST_REQ: begin
          if (rd_ready_i) begin
            rd_req_q <= 1'b0;
            state_q  <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (rd_valid_i) begin
            lb_we_q    <= 1'b1;
            lb_bank_q  <= bank_i;
            lb_addr_q  <= pix_q;
            lb_wdata_q <= rd_data_i;
            pix_q      <= pix_q + LB_AW'(1);
            beat_q     <= beat_q + 8'd1;
            if (beat_q == 8'(BURST_LEN - 1)) begin
              beat_q <= '0;
              if (pix_q == LB_AW'(OVL_W - 1)) begin
                state_q <= ST_DONE;
              end else begin
                state_q   <= ST_REQ;
                rd_req_q  <= 1'b1;
                rd_addr_q <= rd_addr_q + ADDR_W'(BURST_LEN);
              end
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy_o     = (state_q == ST_REQ) || (state_q == ST_DATA);
  assign done_o     = (state_q == ST_DONE);
  assign rd_req_o   = rd_req_q;
  assign rd_addr_o  = rd_addr_q;
  assign rd_len_o   = 8'(BURST_LEN);
  assign lb_we_o    = lb_we_q;
  assign lb_bank_o  = lb_bank_q;
  assign lb_addr_o  = lb_addr_q;
  assign lb_wdata_o = lb_wdata_q;

endmodule

// File: rtl/overlay_fetch_ctrl.sv
// rtl/overlay_fetch_ctrl.sv - per-line overlay row prefetch into a ping-pong line buffer; OVL_UNDERRUN_CNT_EN adds underrun_cnt
module overlay_fetch_ctrl
  import overlay_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       DATA_W    = 24,
  parameter int unsigned       OVL_W     = OVL_WIDTH,
  parameter int unsigned       OVL_H     = 256,
  parameter int unsigned       BURST_LEN = OVL_BURST_LEN,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       vBusWidth = 12
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        frame_start,
  input  logic                        line_start,
  input  logic [vBusWidth-1:0]        vCount,
  input  logic [vBusWidth-1:0]        ovl_y,
  output logic                        rd_req,
  output logic [ADDR_W-1:0]           rd_addr,
  output logic [7:0]                  rd_len,
  input  logic                        rd_ready,
  input  logic                        rd_valid,
  input  logic [DATA_W-1:0]           rd_data,
  output logic                        lb_we,
  output logic                        lb_bank,
  output logic [lb_addr_w(OVL_W)-1:0] lb_addr,
  output logic [DATA_W-1:0]           lb_wdata,
  output logic                        disp_bank,
  output logic                        disp_valid,
  output logic                        underrun
`ifdef OVL_UNDERRUN_CNT_EN
  ,
  output logic [15:0]                 underrun_cnt
`endif
);

  localparam int unsigned VW = vBusWidth + 1;

  logic [vBusWidth-1:0] ovl_y_q;
  logic                 en_q;
  logic                 fill_q;
  logic                 row_ready_q;
  logic                 discard_q;
  logic                 disp_bank_q;
  logic                 disp_valid_q;
  logic                 underrun_q;

  logic                 trig;
  logic                 en_eff;
  logic [VW-1:0]        target;
  logic [VW-1:0]        y_eff;
  logic [VW-1:0]        y_end;
  logic [VW-1:0]        row;
  logic                 in_range;
  logic                 go;
  logic                 busy;
  logic                 done;
  logic                 row_ready_eff;
  logic [ADDR_W-1:0]    row_addr;

  // Trigger decode and range check; a frame_start uses its own ovl_y/enable, not the stale latch.
  always_comb begin
    trig          = frame_start | line_start;
    target        = frame_start ? '0 : ({1'b0, vCount} + VW'(1));
    y_eff         = {1'b0, (frame_start ? ovl_y : ovl_y_q)};
    en_eff        = frame_start ? enable : en_q;
    y_end         = y_eff + VW'(OVL_H);
    in_range      = en_eff && (target >= y_eff) && (target < y_end);
    row           = target - y_eff;
    row_addr      = BASE_ADDR + ADDR_W'(row) * ADDR_W'(OVL_W);
    go            = trig && in_range && !busy;
    row_ready_eff = row_ready_q | (done & ~discard_q);
  end

  // Frame latch, bank hand-off at each trigger and underrun bookkeeping.
  always_ff @(posedge clock) begin
    if (reset) begin
      ovl_y_q      <= '0;
      en_q         <= 1'b0;
      fill_q       <= 1'b0;
      row_ready_q  <= 1'b0;
      discard_q    <= 1'b0;
      disp_bank_q  <= 1'b0;
      disp_valid_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      if (frame_start) begin
        ovl_y_q <= ovl_y;
        en_q    <= enable;
      end
      if (trig) begin
        if (row_ready_eff) begin
          disp_bank_q  <= fill_q;
          disp_valid_q <= 1'b1;
          fill_q       <= ~fill_q;
        end else begin
          disp_valid_q <= 1'b0;
        end
        row_ready_q <= 1'b0;
      end else if (done) begin
        row_ready_q <= row_ready_eff;
      end
      if (done) begin
        discard_q <= 1'b0;
      end
      // A late row keeps draining but is never shown; the trigger that caught it is dropped.
      if (trig && busy) begin
        underrun_q <= 1'b1;
        discard_q  <= 1'b1;
      end
    end
  end

`ifdef OVL_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt_q;

  // Saturating count of underrun events.
  always_ff @(posedge clock) begin
    if (reset) begin
      underrun_cnt_q <= '0;
    end else if (trig && busy && (underrun_cnt_q != 16'hFFFF)) begin
      underrun_cnt_q <= underrun_cnt_q + 16'd1;
    end
  end

  assign underrun_cnt = underrun_cnt_q;
`endif

  ovl_burst_reader #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .OVL_W     (OVL_W),
    .BURST_LEN (BURST_LEN)
  ) u_reader (
    .clk_i      (clock),
    .rst_i      (reset),
    .go_i       (go),
    .row_addr_i (row_addr),
    .bank_i     (fill_q),
    .busy_o     (busy),
    .done_o     (done),
    .rd_req_o   (rd_req),
    .rd_addr_o  (rd_addr),
    .rd_len_o   (rd_len),
    .rd_ready_i (rd_ready),
    .rd_valid_i (rd_valid),
    .rd_data_i  (rd_data),
    .lb_we_o    (lb_we),
    .lb_bank_o  (lb_bank),
    .lb_addr_o  (lb_addr),
    .lb_wdata_o (lb_wdata)
  );

  assign disp_bank  = disp_bank_q;
  assign disp_valid = disp_valid_q;
  assign underrun   = underrun_q;

endmodule
